// File: rtl/pmp_cfg_writer.sv
// ---------------------------------------------------------------------------
// pmp_cfg_writer
//
// Configuration-side programmer for the PMP/DMP checker. Takes one command at
// a time over a valid/ready request channel, validates it, turns a base/size
// region into the PMP NA4/NAPOT address encoding, and updates the per-entry
// PMP/DMP configuration or the current domain. A status is returned on a
// valid/ready response channel. All outputs are registers.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_valid_i/ready  command handshake
//   req_op_i           0 WRITE, 1 CLEAR, 2 SET_DOM, 3 reserved
//   req_idx_i          target entry
//   req_base_i         region base byte address
//   req_size_i         log2 of region size in bytes
//   req_access_i       R/W/X rights for WRITE
//   req_lock_i         lock the entry on WRITE
//   req_domain_i       entry domain (WRITE) or new current domain (SET_DOM)
//   rsp_valid_o/ready  response handshake
//   rsp_err_o          command rejected
//   rsp_code_o         0 OK, 1 LOCKED, 2 ALIGN/SIZE, 3 BAD_OP/IDX
//   conf_addr_o        encoded entry addresses
//   pmpconf_o          per-entry PMP configuration
//   dmpconf_o          per-entry DMP configuration
//   curdom_o           current domain
// ---------------------------------------------------------------------------
package riscv;
    typedef enum logic [1:0] {OFF = 2'b00, TOR = 2'b01, NA4 = 2'b10, NAPOT = 2'b11} pmp_addr_mode_t;

    typedef struct packed {
        logic x;
        logic w;
        logic r;
    } pmp_access_t;

    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        pmp_access_t    access_type;
    } pmpcfg_t;

    typedef enum logic [1:0] {DOM0 = 2'd0, DOM1 = 2'd1, DOM2 = 2'd2, DOMI = 2'd3} dmp_domain_t;

    typedef struct packed {
        dmp_domain_t domain;
    } dmpcfg_t;
endpackage

module pmp_cfg_writer
    import riscv::*;
#(
    parameter int unsigned PLEN       = 56,
    parameter int unsigned PMP_LEN    = 54,
    parameter int unsigned NR_ENTRIES = 16,
    localparam int unsigned IDX_W     = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [1:0]                           req_op_i,
    input  logic [IDX_W-1:0]                     req_idx_i,
    input  logic [PLEN-1:0]                      req_base_i,
    input  logic [7:0]                           req_size_i,
    input  pmp_access_t                          req_access_i,
    input  logic                                 req_lock_i,
    input  dmp_domain_t                          req_domain_i,
    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,
    output logic                                 rsp_err_o,
    output logic [1:0]                           rsp_code_o,
    output logic [NR_ENTRIES-1:0][PMP_LEN-1:0]   conf_addr_o,
    output pmpcfg_t [NR_ENTRIES-1:0]             pmpconf_o,
    output dmpcfg_t [NR_ENTRIES-1:0]             dmpconf_o,
    output dmp_domain_t                          curdom_o
);

    localparam logic [1:0] OP_WRITE   = 2'd0;
    localparam logic [1:0] OP_CLEAR   = 2'd1;
    localparam logic [1:0] OP_SET_DOM = 2'd2;
    localparam logic [1:0] OP_RSVD    = 2'd3;

    typedef enum logic [1:0] {IDLE, CHECK, COMMIT, RESP} state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [IDX_W-1:0]  idx_q;
    logic [PLEN-1:0]   base_q;
    logic [7:0]        size_q;
    pmp_access_t       access_q;
    logic              lock_q;
    dmp_domain_t       domain_q;
    logic [1:0]        code_q;

    logic                 idx_ok;
    logic                 locked_hit;
    logic                 size_bad;
    logic                 misaligned;
    logic [PLEN-1:0]      low_mask;
    logic [PMP_LEN-1:0]   napot_mask;
    logic [PMP_LEN-1:0]   enc_addr;
    pmp_addr_mode_t       enc_mode;
    logic [1:0]           code_next;

    // Validation and address encoding, derived only from the captured
    // command and the current entry state (never from the live req_* pins).
    always_comb begin
        idx_ok     = 32'(idx_q) < NR_ENTRIES;
        locked_hit = idx_ok && pmpconf_o[idx_q].locked;
        size_bad   = (size_q < 8'd2) || (32'(size_q) > PLEN);
        // Bits of base below 'size' must be zero; a shift past the width
        // yields an all-ones mask, which covers size == PLEN.
        low_mask   = ~({PLEN{1'b1}} << size_q);
        misaligned = |(base_q & low_mask);
        // NAPOT fills the (size-3) low bits of the word address with ones.
        napot_mask = ~({PMP_LEN{1'b1}} << (size_q - 8'd3));
        enc_addr   = base_q[PMP_LEN+1:2] | ((size_q >= 8'd3) ? napot_mask : '0);
        enc_mode   = (size_q == 8'd2) ? NA4 : NAPOT;

        code_next = 2'd0;
        if (op_q == OP_RSVD || !idx_ok) begin
            code_next = 2'd3;
        end else if ((op_q == OP_WRITE || op_q == OP_CLEAR) && locked_hit) begin
            code_next = 2'd1;
        end else if (op_q == OP_WRITE && (size_bad || misaligned)) begin
            code_next = 2'd2;
        end
    end

    // Command sequencer and configuration registers. The error path still
    // passes through COMMIT (without writing) so every response appears at
    // the same latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            op_q        <= '0;
            idx_q       <= '0;
            base_q      <= '0;
            size_q      <= '0;
            access_q    <= '0;
            lock_q      <= 1'b0;
            domain_q    <= DOM0;
            code_q      <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_code_o  <= '0;
            conf_addr_o <= '0;
            pmpconf_o   <= '0;
            dmpconf_o   <= '0;
            curdom_o    <= DOM0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        op_q        <= req_op_i;
                        idx_q       <= req_idx_i;
                        base_q      <= req_base_i;
                        size_q      <= req_size_i;
                        access_q    <= req_access_i;
                        lock_q      <= req_lock_i;
                        domain_q    <= req_domain_i;
                        req_ready_o <= 1'b0;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    code_q <= code_next;
                    state  <= COMMIT;
                end
                COMMIT: begin
                    if (code_q == 2'd0) begin
                        case (op_q)
                            OP_WRITE: begin
                                conf_addr_o[idx_q]             <= enc_addr;
                                pmpconf_o[idx_q].locked        <= lock_q;
                                pmpconf_o[idx_q].reserved      <= 2'b00;
                                pmpconf_o[idx_q].addr_mode     <= enc_mode;
                                pmpconf_o[idx_q].access_type   <= access_q;
                                dmpconf_o[idx_q].domain        <= domain_q;
                            end
                            OP_CLEAR: begin
                                // Entry is known unlocked here, so the
                                // whole pmpcfg byte goes to zero.
                                conf_addr_o[idx_q] <= '0;
                                pmpconf_o[idx_q]   <= '0;
                            end
                            OP_SET_DOM: begin
                                curdom_o <= domain_q;
                            end
                            default: begin
                            end
                        endcase
                    end
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= (code_q != 2'd0);
                    rsp_code_o  <= code_q;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_cfg_writer.sv
// ---------------------------------------------------------------------------
// tb_pmp_cfg_writer
//
// Self-checking bench for pmp_cfg_writer (PLEN=16, PMP_LEN=13, 4 entries)
// plus a 5-entry instance for the 3-bit index case. Directed scenarios use
// literal expected values; the randomized scenario is checked against an
// arithmetic reference model of the entry table.
// ---------------------------------------------------------------------------
module tb_pmp_cfg_writer;
    import riscv::*;

    localparam int PLEN    = 16;
    localparam int PMP_LEN = 13;
    localparam int NR      = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                          req_valid, req_ready;
    logic [1:0]                    req_op;
    logic [1:0]                    req_idx;
    logic [PLEN-1:0]               req_base;
    logic [7:0]                    req_size;
    pmp_access_t                   req_access;
    logic                          req_lock;
    dmp_domain_t                   req_domain;
    logic                          rsp_valid, rsp_ready, rsp_err;
    logic [1:0]                    rsp_code;
    logic [NR-1:0][PMP_LEN-1:0]    conf_addr;
    pmpcfg_t [NR-1:0]              pmpconf;
    dmpcfg_t [NR-1:0]              dmpconf;
    dmp_domain_t                   curdom;

    logic                          v_req_valid, v_req_ready;
    logic [2:0]                    v_req_idx;
    logic                          v_rsp_valid, v_rsp_err;
    logic [1:0]                    v_rsp_code;
    logic [4:0][PMP_LEN-1:0]       v_conf_addr;
    pmpcfg_t [4:0]                 v_pmpconf;
    dmpcfg_t [4:0]                 v_dmpconf;
    dmp_domain_t                   v_curdom;

    pmp_cfg_writer #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_idx_i(req_idx), .req_base_i(req_base),
        .req_size_i(req_size), .req_access_i(req_access), .req_lock_i(req_lock),
        .req_domain_i(req_domain),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_err_o(rsp_err), .rsp_code_o(rsp_code),
        .conf_addr_o(conf_addr), .pmpconf_o(pmpconf),
        .dmpconf_o(dmpconf), .curdom_o(curdom)
    );

    pmp_cfg_writer #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(5)) dut5 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(v_req_valid), .req_ready_o(v_req_ready),
        .req_op_i(req_op), .req_idx_i(v_req_idx), .req_base_i(req_base),
        .req_size_i(req_size), .req_access_i(req_access), .req_lock_i(req_lock),
        .req_domain_i(req_domain),
        .rsp_valid_o(v_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_err_o(v_rsp_err), .rsp_code_o(v_rsp_code),
        .conf_addr_o(v_conf_addr), .pmpconf_o(v_pmpconf),
        .dmpconf_o(v_dmpconf), .curdom_o(v_curdom)
    );

    int errors = 0;
    int checks = 0;

    // Reference model of the entry table
    logic [PMP_LEN-1:0] m_addr [NR];
    pmp_addr_mode_t     m_mode [NR];
    logic [2:0]         m_acc  [NR];
    bit                 m_lock [NR];
    dmp_domain_t        m_dom  [NR];
    dmp_domain_t        m_curdom;

    bit ready_seen;
    bit mid_rsp_valid;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_addr[i] = '0; m_mode[i] = OFF; m_acc[i] = '0; m_lock[i] = 0; m_dom[i] = DOM0;
        end
        m_curdom = DOM0;
    endtask

    // Decide the status from the rules, then apply the command if accepted.
    task automatic model_step(input int op, input int idx, input int base, input int size,
                              input logic [2:0] acc, input bit lock, input dmp_domain_t dom,
                              output int code);
        int word;
        if (op == 3 || idx >= NR) code = 3;
        else if (op != 2 && m_lock[idx]) code = 1;
        else if (op == 0 && (size < 2 || size > PLEN || (base % (1 << size)) != 0)) code = 2;
        else code = 0;
        if (code == 0) begin
            if (op == 0) begin
                word = base / 4;
                if (size >= 3) word = word | ((1 << (size - 3)) - 1);
                m_addr[idx] = word[PMP_LEN-1:0];
                m_mode[idx] = (size == 2) ? NA4 : NAPOT;
                m_acc[idx]  = acc;
                m_lock[idx] = lock;
                m_dom[idx]  = dom;
            end else if (op == 1) begin
                m_addr[idx] = '0; m_mode[idx] = OFF; m_acc[idx] = '0;
            end else if (op == 2) begin
                m_curdom = dom;
            end
        end
    endtask

    // Drive one command; returns at the falling edge after edge 2.
    task automatic send_cmd(input int op, input int idx, input int base, input int size,
                            input logic [2:0] acc, input bit lock, input dmp_domain_t dom);
        @(negedge clk);
        ready_seen = req_ready;
        req_op = op[1:0]; req_idx = idx[1:0]; req_base = base[PLEN-1:0];
        req_size = size[7:0]; req_access = pmp_access_t'(acc); req_lock = lock;
        req_domain = dom; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mid_rsp_valid = rsp_valid;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic finish_rsp();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset req_ready: got %b expected 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_code !== 2'd0) begin
            errors++; $display("[TB] FAIL reset rsp: got v=%b e=%b c=%0d expected 0/0/0", rsp_valid, rsp_err, rsp_code); end
        checks++; if (conf_addr !== '0) begin errors++; $display("[TB] FAIL reset conf_addr: got %h expected 0", conf_addr); end
        checks++; if (pmpconf !== '0) begin errors++; $display("[TB] FAIL reset pmpconf: got %h expected 0", pmpconf); end
        checks++; if (dmpconf !== '0 || curdom !== DOM0) begin
            errors++; $display("[TB] FAIL reset domains: got dmp=%h cur=%0d expected 0/0", dmpconf, curdom); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL post-reset req_ready: got %b expected 1", req_ready); end
        model_reset();
    endtask

    task automatic test_plan_writes();
        int code;
        model_step(0, 1, 'h19B8, 3, 3'b001, 0, DOM0, code);
        send_cmd(0, 1, 'h19B8, 3, 3'b001, 0, DOM0);
        checks++; if (ready_seen !== 1'b1) begin errors++; $display("[TB] FAIL w1 req_ready: got %b expected 1", ready_seen); end
        checks++; if (mid_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL w1 early rsp_valid: got %b expected 0", mid_rsp_valid); end
        checks++; if (conf_addr[1] !== 13'h066E) begin errors++; $display("[TB] FAIL w1 conf_addr: got %h expected 066e", conf_addr[1]); end
        checks++; if (pmpconf[1].addr_mode !== NAPOT || pmpconf[1].access_type !== 3'b001 || pmpconf[1].locked !== 1'b0) begin
            errors++; $display("[TB] FAIL w1 pmpconf: got %h expected 19", pmpconf[1]); end
        checks++; if (dmpconf[1].domain !== DOM0) begin errors++; $display("[TB] FAIL w1 domain: got %0d expected 0", dmpconf[1].domain); end
        checks++; if (rsp_valid !== 1'b1 || rsp_code !== 2'd0 || rsp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL w1 rsp: got v=%b c=%0d e=%b expected 1/0/0", rsp_valid, rsp_code, rsp_err); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL w1 busy ready: got %b expected 0", req_ready); end
        finish_rsp();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL w1 handshake: got v=%b r=%b expected 0/1", rsp_valid, req_ready); end

        model_step(0, 3, 'h1900, 8, 3'b111, 0, DOM1, code);
        send_cmd(0, 3, 'h1900, 8, 3'b111, 0, DOM1);
        checks++; if (conf_addr[3] !== 13'h065F) begin errors++; $display("[TB] FAIL w3 conf_addr: got %h expected 065f", conf_addr[3]); end
        finish_rsp();
        model_step(0, 2, 'h19B0, 4, 3'b011, 0, DOM2, code);
        send_cmd(0, 2, 'h19B0, 4, 3'b011, 0, DOM2);
        checks++; if (conf_addr[2] !== 13'h066D) begin errors++; $display("[TB] FAIL w2 conf_addr: got %h expected 066d", conf_addr[2]); end
        finish_rsp();
        model_step(0, 0, 'h19BC, 2, 3'b101, 0, DOM1, code);
        send_cmd(0, 0, 'h19BC, 2, 3'b101, 0, DOM1);
        checks++; if (conf_addr[0] !== 13'h066F || pmpconf[0].addr_mode !== NA4) begin
            errors++; $display("[TB] FAIL w0 na4: got addr=%h mode=%0d expected 066f/2", conf_addr[0], pmpconf[0].addr_mode); end
        finish_rsp();
    endtask

    task automatic test_errors();
        int code;
        model_step(0, 1, 'h19BA, 3, 3'b111, 0, DOM2, code);
        send_cmd(0, 1, 'h19BA, 3, 3'b111, 0, DOM2);
        checks++; if (rsp_code !== 2'd2 || rsp_err !== 1'b1) begin
            errors++; $display("[TB] FAIL misalign rsp: got c=%0d e=%b expected 2/1", rsp_code, rsp_err); end
        checks++; if (conf_addr[1] !== 13'h066E || pmpconf[1] !== 8'h19 || dmpconf[1].domain !== DOM0) begin
            errors++; $display("[TB] FAIL misalign entry: got %h/%h expected 066e/19", conf_addr[1], pmpconf[1]); end
        finish_rsp();
        model_step(3, 0, 0, 4, 3'b111, 0, DOM1, code);
        send_cmd(3, 0, 0, 4, 3'b111, 0, DOM1);
        checks++; if (rsp_code !== 2'd3 || rsp_err !== 1'b1) begin
            errors++; $display("[TB] FAIL badop rsp: got c=%0d e=%b expected 3/1", rsp_code, rsp_err); end
        checks++; if (conf_addr[0] !== 13'h066F || curdom !== DOM0) begin
            errors++; $display("[TB] FAIL badop state: got %h cur=%0d expected 066f/0", conf_addr[0], curdom); end
        finish_rsp();
        model_step(0, 2, 'h0000, 1, 3'b001, 0, DOM0, code);
        send_cmd(0, 2, 'h0000, 1, 3'b001, 0, DOM0);
        checks++; if (rsp_code !== 2'd2) begin errors++; $display("[TB] FAIL size1 rsp: got %0d expected 2", rsp_code); end
        finish_rsp();
    endtask

    task automatic test_idx_variant();
        int idx_list [2] = '{4, 6};
        int exp_code [2] = '{0, 3};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_op = 2'd0; v_req_idx = idx_list[k][2:0]; req_base = 16'h0100; req_size = 8'd8;
            req_access = pmp_access_t'(3'b011); req_lock = 1'b0; req_domain = DOM1; v_req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            v_req_valid = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            checks++; if (v_rsp_valid !== 1'b1 || v_rsp_code !== exp_code[k][1:0] || v_rsp_err !== (exp_code[k] != 0)) begin
                errors++; $display("[TB] FAIL variant idx%0d rsp: got v=%b c=%0d expected 1/%0d", idx_list[k], v_rsp_valid, v_rsp_code, exp_code[k]); end
            checks++; if (v_conf_addr[4] !== 13'h005F) begin
                errors++; $display("[TB] FAIL variant idx%0d entry4: got %h expected 005f", idx_list[k], v_conf_addr[4]); end
            finish_rsp();
        end
    endtask

    task automatic test_lock();
        int code;
        model_step(0, 3, 'h1900, 8, 3'b111, 1, DOM1, code);
        send_cmd(0, 3, 'h1900, 8, 3'b111, 1, DOM1);
        checks++; if (rsp_code !== 2'd0 || pmpconf[3].locked !== 1'b1) begin
            errors++; $display("[TB] FAIL lock set: got c=%0d l=%b expected 0/1", rsp_code, pmpconf[3].locked); end
        finish_rsp();
        model_step(0, 3, 'h0000, 4, 3'b001, 0, DOM2, code);
        send_cmd(0, 3, 'h0000, 4, 3'b001, 0, DOM2);
        checks++; if (rsp_code !== 2'd1 || rsp_err !== 1'b1) begin
            errors++; $display("[TB] FAIL locked write rsp: got c=%0d e=%b expected 1/1", rsp_code, rsp_err); end
        finish_rsp();
        model_step(1, 3, 0, 0, 3'b000, 0, DOM0, code);
        send_cmd(1, 3, 0, 0, 3'b000, 0, DOM0);
        checks++; if (rsp_code !== 2'd1) begin errors++; $display("[TB] FAIL locked clear rsp: got %0d expected 1", rsp_code); end
        checks++; if (conf_addr[3] !== 13'h065F || pmpconf[3] !== 8'h9F || dmpconf[3].domain !== DOM1) begin
            errors++; $display("[TB] FAIL locked entry: got %h/%h expected 065f/9f", conf_addr[3], pmpconf[3]); end
        finish_rsp();
        rst_n = 1'b0;
        #1;
        checks++; if (conf_addr[3] !== '0 || pmpconf[3] !== '0) begin
            errors++; $display("[TB] FAIL lock reset: got %h/%h expected 0/0", conf_addr[3], pmpconf[3]); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_backpressure();
        int code;
        rsp_ready = 1'b0;
        model_step(2, 0, 0, 0, 3'b000, 0, DOM2, code);
        send_cmd(2, 0, 0, 0, 3'b000, 0, DOM2);
        checks++; if (curdom !== DOM2 || rsp_valid !== 1'b1 || rsp_code !== 2'd0) begin
            errors++; $display("[TB] FAIL setdom: got cur=%0d v=%b c=%0d expected 2/1/0", curdom, rsp_valid, rsp_code); end
        req_op = 2'd0; req_idx = 2'd0; req_base = 16'h1000; req_size = 8'd12; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_code !== 2'd0 || req_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL stall %0d: got v=%b c=%0d r=%b expected 1/0/0", i, rsp_valid, rsp_code, req_ready); end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        finish_rsp();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL stall release: got v=%b r=%b expected 0/1", rsp_valid, req_ready); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || conf_addr[0] !== m_addr[0] || pmpconf[0] !== '0) begin
            errors++; $display("[TB] FAIL stall ignored req: got v=%b a=%h expected 0/%h", rsp_valid, conf_addr[0], m_addr[0]); end
    endtask

    task automatic test_random();
        int op, idx, base, size, code, r;
        logic [2:0] acc;
        bit lock;
        dmp_domain_t dom;
        pmpcfg_t exp_cfg;
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            op = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
            idx = $urandom_range(0, NR - 1);
            size = $urandom_range(0, 18);
            base = $urandom_range(0, 16'hFFFF);
            if ($urandom_range(0, 3) != 0 && size <= PLEN) base = base - (base % (1 << size));
            acc = 3'($urandom_range(0, 7));
            lock = ($urandom_range(0, 15) == 0);
            dom = dmp_domain_t'($urandom_range(0, 3));
            model_step(op, idx, base, size, acc, lock, dom, code);
            send_cmd(op, idx, base, size, acc, lock, dom);
            checks++; if (ready_seen !== 1'b1 || mid_rsp_valid !== 1'b0 || rsp_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL rand #%0d timing: got rdy=%b mid=%b v=%b expected 1/0/1", n, ready_seen, mid_rsp_valid, rsp_valid); end
            checks++; if (rsp_code !== code[1:0] || rsp_err !== (code != 0)) begin
                errors++; $display("[TB] FAIL rand #%0d rsp (op%0d idx%0d base %h size %0d): got c=%0d expected %0d", n, op, idx, base, size, rsp_code, code); end
            for (int i = 0; i < NR; i++) begin
                exp_cfg = '{locked: m_lock[i], reserved: 2'b00, addr_mode: m_mode[i], access_type: pmp_access_t'(m_acc[i])};
                checks++; if (conf_addr[i] !== m_addr[i]) begin
                    errors++; $display("[TB] FAIL rand #%0d conf_addr[%0d]: got %h expected %h", n, i, conf_addr[i], m_addr[i]); end
                checks++; if (pmpconf[i] !== exp_cfg || dmpconf[i].domain !== m_dom[i]) begin
                    errors++; $display("[TB] FAIL rand #%0d cfg[%0d]: got %h/%0d expected %h/%0d", n, i, pmpconf[i], dmpconf[i].domain, exp_cfg, m_dom[i]); end
            end
            checks++; if (curdom !== m_curdom) begin
                errors++; $display("[TB] FAIL rand #%0d curdom: got %0d expected %0d", n, curdom, m_curdom); end
            finish_rsp();
        end
    endtask

    task automatic test_reset_midcmd();
        int seen;
        @(negedge clk);
        req_op = 2'd0; req_idx = 2'd2; req_base = 16'h0100; req_size = 8'd8;
        req_access = pmp_access_t'(3'b111); req_lock = 1'b0; req_domain = DOM1; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_code !== 2'd0) begin
            errors++; $display("[TB] FAIL midreset handshake: got r=%b v=%b e=%b c=%0d expected 1/0/0/0", req_ready, rsp_valid, rsp_err, rsp_code); end
        checks++; if (conf_addr !== '0 || pmpconf !== '0 || dmpconf !== '0 || curdom !== DOM0) begin
            errors++; $display("[TB] FAIL midreset state: got addr=%h cfg=%h cur=%0d expected all 0", conf_addr, pmpconf, curdom); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0 || conf_addr[2] !== '0) begin
            errors++; $display("[TB] FAIL midreset discard: got rsp cycles=%0d addr=%h expected 0/0", seen, conf_addr[2]); end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; v_req_valid = 1'b0; rsp_ready = 1'b1;
        req_op = '0; req_idx = '0; v_req_idx = '0; req_base = '0; req_size = '0;
        req_access = '0; req_lock = 1'b0; req_domain = DOM0;
        test_reset();
        test_plan_writes();
        test_errors();
        test_idx_variant();
        test_lock();
        test_backpressure();
        test_random();
        test_reset_midcmd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
